bayer_capture: RTL and testbench

Front-end stage that converts the sensor's raw frame/line-valid pixel stream into the Bayer byte stream consumed by the processing pipeline (`newFrame`, `iValid`, `iData`). It synchronises to whole frames and crops a `width` × `height` window at (`xStart`, `yStart`). It truncates each pixel to 8 bits and flags frames that end early. It sits directly upstream of the demosaic/filter processing block.

---
 rtl/bayer_capture.sv | 174 +++++++++++++++++
 tb/tb_bayer_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_capture.sv
// bayer_capture: turns the sensor's frame/line-valid pixel stream into the
// cropped 8-bit Bayer stream for the processing pipeline. Captures only whole
// frames, crops a width x height window at (xStart, yStart) and flags frames
// that end before their last window pixel.
module bayer_capture #(
  parameter int width  = 320,
  parameter int height = 240,
  parameter int xStart = 0,
  parameter int yStart = 0,
  parameter int inBits = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              iFval,
  input  logic              iLval,
  input  logic [inBits-1:0] iPixel,
  output logic              oNewFrame,
  output logic              oValid,
  output logic [7:0]        oData,
  output logic [15:0]       oX,
  output logic [15:0]       oY,
  output logic              oFrameDone,
  output logic [15:0]       oFrameCnt,
  output logic              oError
);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_FRAME, ACTIVE} state_t;

  // Window bounds carry one extra bit so xStart+width may reach 65536.
  localparam logic [16:0] X_LO = 17'(xStart);
  localparam logic [16:0] X_HI = 17'(xStart + width);
  localparam logic [16:0] Y_LO = 17'(yStart);
  localparam logic [16:0] Y_HI = 17'(yStart + height);

  state_t              state_q;
  logic                fval1_q, lval1_q;
  logic [inBits-1:0]   pix1_q;
  logic                fval2_q, lv2_q, fRise2_q, lRise2_q, lFall2_q;
  logic [7:0]          pix2_q;
  logic [15:0]         row_q, col_q;
  logic                newFrame_q, valid_q, frameDone_q, error_q;
  logic [7:0]          data_q;
  logic [15:0]         x_q, y_q, frameCnt_q;

  logic                lv1;
  logic [15:0]         curCol, col_d, row_d, xOff_d, yOff_d;
  logic                inWin, lastPix;

  // Only the top byte of the pixel travels on; the low bits end here.
  logic unusedPix;
  assign unusedPix = ^pix1_q;

  // A line only counts while the frame is valid, so stray line-valid is dropped.
  assign lv1 = fval1_q & lval1_q;

  // Stage 1 registers the raw sensor pins; stage 2 holds the previous stage-1
  // value together with the edges found by comparing the two.
  always_ff @(posedge clk) begin
    if (reset) begin
      fval1_q  <= 1'b0;
      lval1_q  <= 1'b0;
      pix1_q   <= '0;
      fval2_q  <= 1'b0;
      lv2_q    <= 1'b0;
      fRise2_q <= 1'b0;
      lRise2_q <= 1'b0;
      lFall2_q <= 1'b0;
      pix2_q   <= 8'd0;
    end else begin
      fval1_q  <= iFval;
      lval1_q  <= iLval;
      pix1_q   <= iPixel;
      fval2_q  <= fval1_q;
      lv2_q    <= lv1;
      fRise2_q <= fval1_q & ~fval2_q;
      lRise2_q <= lv1 & ~lv2_q;
      lFall2_q <= ~lv1 & lv2_q;
      pix2_q   <= pix1_q[inBits-1 -: 8];
    end
  end

  // Window test and saturating next row/column for the pixel in stage 2.
  always_comb begin
    curCol  = lRise2_q ? 16'd0 : col_q;
    inWin   = lv2_q &&
              ({1'b0, curCol} >= X_LO) && ({1'b0, curCol} < X_HI) &&
              ({1'b0, row_q}  >= Y_LO) && ({1'b0, row_q}  < Y_HI);
    lastPix = inWin &&
              ({1'b0, curCol} == X_HI - 17'd1) &&
              ({1'b0, row_q}  == Y_HI - 17'd1);
    col_d   = col_q;
    if (lv2_q) begin
      col_d = (curCol == 16'hFFFF) ? curCol : curCol + 16'd1;
    end
    row_d   = row_q;
    if (lFall2_q) begin
      row_d = (row_q == 16'hFFFF) ? row_q : row_q + 16'd1;
    end
    xOff_d  = curCol - X_LO[15:0];
    yOff_d  = row_q - Y_LO[15:0];
  end

  // Frame-sync state machine with registered outputs; WAIT_LOW forces a full
  // low-to-high frame-valid cycle so capture never starts mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= 16'd0;
      col_q       <= 16'd0;
      newFrame_q  <= 1'b0;
      valid_q     <= 1'b0;
      frameDone_q <= 1'b0;
      error_q     <= 1'b0;
      data_q      <= 8'd0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      frameCnt_q  <= 16'd0;
    end else begin
      newFrame_q  <= 1'b0;
      valid_q     <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!fval1_q && !fval2_q) state_q <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (fRise2_q) begin
            newFrame_q <= 1'b1;
            row_q      <= 16'd0;
            col_q      <= 16'd0;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!fval2_q) begin
            error_q <= 1'b1;
            state_q <= WAIT_LOW;
          end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (inWin) begin
              valid_q <= 1'b1;
              data_q  <= pix2_q;
              x_q     <= xOff_d;
              y_q     <= yOff_d;
            end
            if (lastPix) begin
              frameDone_q <= 1'b1;
              frameCnt_q  <= frameCnt_q + 16'd1;
              state_q     <= WAIT_LOW;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oNewFrame  = newFrame_q;
  assign oValid     = valid_q;
  assign oData      = data_q;
  assign oX         = x_q;
  assign oY         = y_q;
  assign oFrameDone = frameDone_q;
  assign oFrameCnt  = frameCnt_q;
  assign oError     = error_q;

endmodule

// File: tb/tb_bayer_capture.sv
// Bench for bayer_capture: three instances (4x3 window at origin, 2x2 crop at
// (2,1), 1x1 window) share one sensor stream and are checked every cycle
// against a frame-level reference model, plus directed literal checks.
module tb_bayer_capture;

  logic        clk = 1'b0;
  logic        reset, enable, iFval, iLval;
  logic [11:0] iPixel;

  logic [2:0]       oNewFrame, oValid, oFrameDone, oError;
  logic [2:0][7:0]  oData;
  logic [2:0][15:0] oX, oY, oFrameCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bayer_capture #(.width(4), .height(3), .xStart(0), .yStart(0), .inBits(12)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .iFval(iFval), .iLval(iLval), .iPixel(iPixel),
    .oNewFrame(oNewFrame[0]), .oValid(oValid[0]), .oData(oData[0]), .oX(oX[0]), .oY(oY[0]),
    .oFrameDone(oFrameDone[0]), .oFrameCnt(oFrameCnt[0]), .oError(oError[0]));

  bayer_capture #(.width(2), .height(2), .xStart(2), .yStart(1), .inBits(12)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .iFval(iFval), .iLval(iLval), .iPixel(iPixel),
    .oNewFrame(oNewFrame[1]), .oValid(oValid[1]), .oData(oData[1]), .oX(oX[1]), .oY(oY[1]),
    .oFrameDone(oFrameDone[1]), .oFrameCnt(oFrameCnt[1]), .oError(oError[1]));

  bayer_capture #(.width(1), .height(1), .xStart(0), .yStart(0), .inBits(12)) dutC (
    .clk(clk), .reset(reset), .enable(enable), .iFval(iFval), .iLval(iLval), .iPixel(iPixel),
    .oNewFrame(oNewFrame[2]), .oValid(oValid[2]), .oData(oData[2]), .oX(oX[2]), .oY(oY[2]),
    .oFrameDone(oFrameDone[2]), .oFrameCnt(oFrameCnt[2]), .oError(oError[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: window geometry per instance and the sensor history it
  // sees (each decision acts on the sample taken two edges earlier).
  int W[3]  = '{4, 2, 1};
  int H[3]  = '{3, 2, 1};
  int XS[3] = '{0, 2, 0};
  int YS[3] = '{0, 1, 0};

  localparam int M_IDLE = 0, M_WAITLOW = 1, M_WAITFRAME = 2, M_ACTIVE = 3;

  typedef struct packed {logic f; logic l; logic [11:0] p;} samp_t;
  samp_t h1, h2, h3;

  int          mMode[3], mRow[3], mCol[3];
  bit          eNew[3], eValid[3], eDone[3], eErr[3];
  logic [7:0]  eData[3];
  logic [15:0] eX[3], eY[3], eCnt[3];

  always @(posedge clk) begin
    if (reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      for (int d = 0; d < 3; d++) begin
        mMode[d] = M_IDLE; mRow[d] = 0; mCol[d] = 0;
        eNew[d] = 0; eValid[d] = 0; eDone[d] = 0; eErr[d] = 0;
        eData[d] = 0; eX[d] = 0; eY[d] = 0; eCnt[d] = 0;
      end
    end else begin
      bit curLv, prvLv;
      curLv = h2.f & h2.l;
      prvLv = h3.f & h3.l;
      for (int d = 0; d < 3; d++) begin
        eNew[d] = 0; eValid[d] = 0; eDone[d] = 0;
        case (mMode[d])
          M_IDLE:    if (enable) mMode[d] = M_WAITLOW;
          M_WAITLOW: if (!h1.f && !h2.f) mMode[d] = M_WAITFRAME;
          M_WAITFRAME: begin
            if (!enable) mMode[d] = M_IDLE;
            else if (h2.f && !h3.f) begin
              eNew[d] = 1; mRow[d] = 0; mCol[d] = 0; mMode[d] = M_ACTIVE;
            end
          end
          default: begin
            if (!h2.f) begin
              eErr[d] = 1; mMode[d] = M_WAITLOW;
            end else if (curLv) begin
              if (!prvLv) mCol[d] = 0;
              if (mCol[d] >= XS[d] && mCol[d] < XS[d] + W[d] &&
                  mRow[d] >= YS[d] && mRow[d] < YS[d] + H[d]) begin
                eValid[d] = 1;
                eData[d]  = h2.p[11:4];
                eX[d]     = 16'(mCol[d] - XS[d]);
                eY[d]     = 16'(mRow[d] - YS[d]);
                if (int'(eX[d]) == W[d] - 1 && int'(eY[d]) == H[d] - 1) begin
                  eDone[d] = 1; eCnt[d] = eCnt[d] + 16'd1; mMode[d] = M_WAITLOW;
                end
              end
              if (mCol[d] < 65535) mCol[d]++;
            end else if (prvLv) begin
              if (mRow[d] < 65535) mRow[d]++;
            end
          end
        endcase
      end
      h3 = h2; h2 = h1; h1 = {iFval, iLval, iPixel};
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("d%0d.newFrame", d), oNewFrame[d], eNew[d]);
      checkOutput($sformatf("d%0d.valid", d), oValid[d], eValid[d]);
      checkOutput($sformatf("d%0d.frameDone", d), oFrameDone[d], eDone[d]);
      checkOutput($sformatf("d%0d.frameCnt", d), oFrameCnt[d], eCnt[d]);
      checkOutput($sformatf("d%0d.error", d), oError[d], eErr[d]);
      if (eValid[d]) begin
        checkOutput($sformatf("d%0d.data", d), oData[d], eData[d]);
        checkOutput($sformatf("d%0d.x", d), oX[d], eX[d]);
        checkOutput($sformatf("d%0d.y", d), oY[d], eY[d]);
      end
    end
  end

  // Recorder of emitted pixels for the directed literal checks.
  typedef struct packed {logic [7:0] d; logic [15:0] x; logic [15:0] y;} pix_t;
  pix_t qA[$], qB[$];
  int   nNewA = 0, nDoneA = 0;

  always @(negedge clk) begin
    if (oValid[0] === 1'b1) qA.push_back({oData[0], oX[0], oY[0]});
    if (oValid[1] === 1'b1) qB.push_back({oData[1], oX[1], oY[1]});
    if (oNewFrame[0] === 1'b1) nNewA++;
    if (oFrameDone[0] === 1'b1) nDoneA++;
  end

  // One sensor frame. mode 0: pixel n = 0x0A0 + 16n; mode 1: {line, col} in
  // the top byte; otherwise random. stopAfter truncates, resetAt pulses reset
  // on that pixel, armAt raises enable at the start of that line.
  task automatic applyStimulus(input int lines, input int len, input int mode,
                               input int stopAfter, input int resetAt, input int armAt);
    int n = 0;
    @(negedge clk);
    iFval = 1; iLval = 0;
    repeat (1 + $urandom_range(0, 1)) @(negedge clk);
    for (int ln = 0; ln < lines && ln < stopAfter; ln++) begin
      if (ln == armAt) enable = 1;
      for (int c = 0; c < len; c++) begin
        iLval = 1;
        case (mode)
          0:       iPixel = 12'h0A0 + 12'(n << 4);
          1:       iPixel = 12'((ln << 8) | (c << 4));
          default: iPixel = 12'($urandom);
        endcase
        reset = (n == resetAt);
        @(negedge clk);
        if (reset) begin
          checkOutput("reset.valid", oValid[0], 0);
          checkOutput("reset.newFrame", oNewFrame[0], 0);
          checkOutput("reset.data", oData[0], 0);
          checkOutput("reset.frameCnt", oFrameCnt[0], 0);
          checkOutput("reset.error", oError[0], 0);
          reset = 0;
        end
        n++;
      end
      iLval = 0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
    reset = 0; iFval = 0; iLval = 0;
    repeat (4 + $urandom_range(0, 2)) begin
      iLval = ($urandom_range(0, 7) == 0);
      iPixel = 12'($urandom);
      @(negedge clk);
    end
    iLval = 0;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] cropData[4] = '{8'h12, 8'h13, 8'h22, 8'h23};

  initial begin
    reset = 1; enable = 0; iFval = 0; iLval = 0; iPixel = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst.newFrame", oNewFrame[0], 0);
    checkOutput("rst.valid", oValid[0], 0);
    checkOutput("rst.data", oData[0], 0);
    checkOutput("rst.x", oX[0], 0);
    checkOutput("rst.y", oY[0], 0);
    checkOutput("rst.frameDone", oFrameDone[0], 0);
    checkOutput("rst.frameCnt", oFrameCnt[0], 0);
    checkOutput("rst.error", oError[0], 0);
    reset = 0; enable = 1;
    repeat (4) @(negedge clk);

    // Basic 3x4 frame into the 4x3 window.
    qA.delete(); qB.delete(); nNewA = 0; nDoneA = 0;
    applyStimulus(3, 4, 0, 99, -1, -1);
    checkOutput("basic.count", qA.size(), 12);
    for (int i = 0; i < qA.size() && i < 12; i++) begin
      checkOutput($sformatf("basic.data%0d", i), qA[i].d, 8'h0A + 8'(i));
      checkOutput($sformatf("basic.x%0d", i), qA[i].x, i % 4);
      checkOutput($sformatf("basic.y%0d", i), qA[i].y, i / 4);
    end
    checkOutput("basic.newFrames", nNewA, 1);
    checkOutput("basic.frameDones", nDoneA, 1);
    checkOutput("basic.frameCnt", oFrameCnt[0], 1);

    // Crop 2x2 at (2,1) from a 4x6 frame.
    qB.delete();
    applyStimulus(4, 6, 1, 99, -1, -1);
    checkOutput("crop.count", qB.size(), 4);
    for (int i = 0; i < qB.size() && i < 4; i++) begin
      checkOutput($sformatf("crop.data%0d", i), qB[i].d, cropData[i]);
      checkOutput($sformatf("crop.x%0d", i), qB[i].x, i % 2);
      checkOutput($sformatf("crop.y%0d", i), qB[i].y, i / 2);
    end
    checkOutput("crop.frameCntA", oFrameCnt[0], 2);

    // Enable raised mid-frame: that frame is skipped, the next one captured.
    enable = 0;
    repeat (6) @(negedge clk);
    qA.delete();
    applyStimulus(3, 4, 0, 99, -1, 1);
    checkOutput("arm.skipped", qA.size(), 0);
    qA.delete();
    applyStimulus(3, 4, 0, 99, -1, -1);
    checkOutput("arm.next", qA.size(), 12);
    checkOutput("arm.frameCnt", oFrameCnt[0], 3);

    // Truncated frame, then a normal one.
    nDoneA = 0;
    applyStimulus(3, 4, 0, 2, -1, -1);
    checkOutput("trunc.error", oError[0], 1);
    checkOutput("trunc.frameCnt", oFrameCnt[0], 3);
    checkOutput("trunc.noDone", nDoneA, 0);
    applyStimulus(3, 4, 0, 99, -1, -1);
    checkOutput("trunc.recover", oFrameCnt[0], 4);
    checkOutput("trunc.sticky", oError[0], 1);

    // Reset after 5 pixels, then a full frame from (0,0).
    applyStimulus(3, 4, 0, 99, 5, -1);
    qA.delete();
    applyStimulus(3, 4, 0, 99, -1, -1);
    checkOutput("rstmid.count", qA.size(), 12);
    if (qA.size() > 0) begin
      checkOutput("rstmid.firstX", qA[0].x, 0);
      checkOutput("rstmid.firstY", qA[0].y, 0);
      checkOutput("rstmid.firstData", qA[0].d, 8'h0A);
    end
    checkOutput("rstmid.frameCnt", oFrameCnt[0], 1);
    checkOutput("rstmid.error", oError[0], 0);

    // Randomised frames: shapes, truncation, enable, stray line-valid, resets.
    repeat (40) begin
      int lines, len, stopAfter, resetAt, armAt;
      lines     = $urandom_range(1, 5);
      len       = $urandom_range(1, 8);
      stopAfter = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lines - 1) : 99;
      resetAt   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, lines * len - 1) : -1;
      enable    = ($urandom_range(0, 4) != 0);
      armAt     = (!enable && $urandom_range(0, 1) == 1) ? $urandom_range(0, lines - 1) : -1;
      applyStimulus(lines, len, 2, stopAfter, resetAt, armAt);
    end

    // Frame counter wrap on the 1x1 instance, preloaded to 16'hFFFE.
    enable = 1;
    repeat (4) @(negedge clk);
    #1;
    force dutC.frameCnt_q = 16'hFFFE;
    eCnt[2] = 16'hFFFE;
    @(negedge clk);
    #1;
    release dutC.frameCnt_q;
    applyStimulus(1, 1, 0, 99, -1, -1);
    checkOutput("wrap.ffff", oFrameCnt[2], 16'hFFFF);
    applyStimulus(1, 1, 0, 99, -1, -1);
    checkOutput("wrap.zero", oFrameCnt[2], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
